// File: rtl/fetch_stage_22_pkg.sv
// Shared constants, fetch-state encoding and instruction field helpers for the
// fetch stage and its IF/ID pipeline register.
package fetch_stage_22_pkg;

   localparam int INSTR_W   = 32;
   localparam int IMM22_MSB = 21;
   localparam int IMM22_LSB = 0;
   localparam int IMM22_W   = IMM22_MSB - IMM22_LSB + 1;

   localparam logic [INSTR_W-1:0] DEFAULT_NOP_INSTR = 32'h0000_0000;
   localparam logic [31:0]        DEFAULT_RESET_PC  = 32'h0000_0000;

   // One state per cycle, chosen fresh every edge; there are no multi-cycle sequences.
   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_WAIT  = 2'd1,
      ST_HOLD  = 2'd2,
      ST_FLUSH = 2'd3
   } fetch_state_e;

   function automatic logic [IMM22_W-1:0] imm22_field(input logic [INSTR_W-1:0] instr);
      return instr[IMM22_MSB:IMM22_LSB];
   endfunction

endpackage

// File: rtl/fetch_stage_22_if_id_reg.sv
// IF/ID pipeline register: captures a fetched word with its PC, or takes a
// bubble on flush, or freezes on hold.
module if_id_reg
   import fetch_stage_22_pkg::*;
#(
   parameter int                  ADDR_W    = 32,
   parameter logic [INSTR_W-1:0]  NOP_INSTR = DEFAULT_NOP_INSTR
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic               flush,
   input  logic               hold,
   input  logic [INSTR_W-1:0] instr,
   input  logic [ADDR_W-1:0]  pc,
   input  logic [ADDR_W-1:0]  pc_next,
   output logic               id_valid,
   output logic [INSTR_W-1:0] id_instr,
   output logic [ADDR_W-1:0]  id_pc,
   output logic [ADDR_W-1:0]  id_pc_next
);

   // Flush outranks hold so a redirect can clear a stalled slot; id_pc keeps
   // the last real PC through bubbles.
   always_ff @(posedge clk) begin
      if (rst) begin
         id_valid   <= 1'b0;
         id_instr   <= NOP_INSTR;
         id_pc      <= '0;
         id_pc_next <= '0;
      end else if (flush) begin
         id_valid   <= 1'b0;
         id_instr   <= NOP_INSTR;
      end else if (hold) begin
         id_valid   <= id_valid;
         id_instr   <= id_instr;
      end else if (load) begin
         id_valid   <= 1'b1;
         id_instr   <= instr;
         id_pc      <= pc;
         id_pc_next <= pc_next;
      end else begin
         id_valid   <= id_valid;
         id_instr   <= id_instr;
      end
   end

endmodule

// File: rtl/fetch_stage_22.sv
// Instruction-fetch stage: PC register, fetch priority (redirect > stall >
// wait state > fetch) and the IF/ID register feeding decode.
module fetch_stage_22
   import fetch_stage_22_pkg::*;
#(
   parameter int                 ADDR_W    = 32,
   parameter logic [ADDR_W-1:0]  RESET_PC  = ADDR_W'(DEFAULT_RESET_PC),
   parameter logic [ADDR_W-1:0]  PC_INC    = ADDR_W'(32'd1),
   parameter logic [INSTR_W-1:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
   input  logic               clk,
   input  logic               rst,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               imem_valid,
   input  logic               stall,
   input  logic               redirect,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               id_valid,
   output logic [INSTR_W-1:0] id_instr,
   output logic [ADDR_W-1:0]  id_pc,
   output logic [ADDR_W-1:0]  id_pc_next,
   output logic [IMM22_W-1:0] id_imm22,
   output logic [31:0]        fetch_count
);

   fetch_state_e      state_s;
   logic [ADDR_W-1:0] pc_r;
   logic [ADDR_W-1:0] pc_inc_s;
   logic [31:0]       fetch_count_r;
   logic              load_s;
   logic              flush_s;
   logic              hold_s;

   // Pick this cycle's fetch state; redirect wins even over a stall.
   always_comb begin
      state_s = ST_FETCH;
      if (redirect) begin
         state_s = ST_FLUSH;
      end else if (stall) begin
         state_s = ST_HOLD;
      end else if (!imem_valid) begin
         state_s = ST_WAIT;
      end else begin
         state_s = ST_FETCH;
      end
   end

   // Wraps modulo 2^ADDR_W by construction.
   assign pc_inc_s = pc_r + PC_INC;

   // Translate the fetch state into IF/ID register controls.
   always_comb begin
      load_s  = 1'b0;
      flush_s = 1'b0;
      hold_s  = 1'b0;
      case (state_s)
         ST_FETCH: load_s  = 1'b1;
         ST_WAIT:  flush_s = 1'b1;
         ST_FLUSH: flush_s = 1'b1;
         ST_HOLD:  hold_s  = 1'b1;
         default:  hold_s  = 1'b1;
      endcase
   end

   // PC and accepted-instruction counter; redirect targets are taken unaligned.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_r          <= RESET_PC;
         fetch_count_r <= 32'd0;
      end else begin
         case (state_s)
            ST_FLUSH: pc_r <= redirect_pc;
            ST_FETCH: begin
               pc_r          <= pc_inc_s;
               fetch_count_r <= fetch_count_r + 32'd1;
            end
            ST_HOLD:  pc_r <= pc_r;
            ST_WAIT:  pc_r <= pc_r;
            default:  pc_r <= pc_r;
         endcase
      end
   end

   if_id_reg #(
      .ADDR_W    (ADDR_W),
      .NOP_INSTR (NOP_INSTR)
   ) u_if_id_reg (
      .clk        (clk),
      .rst        (rst),
      .load       (load_s),
      .flush      (flush_s),
      .hold       (hold_s),
      .instr      (imem_rdata),
      .pc         (pc_r),
      .pc_next    (pc_inc_s),
      .id_valid   (id_valid),
      .id_instr   (id_instr),
      .id_pc      (id_pc),
      .id_pc_next (id_pc_next)
   );

   assign imem_addr   = pc_r;
   assign fetch_count = fetch_count_r;
   assign id_imm22    = imm22_field(id_instr);

endmodule

// File: tb/tb_fetch_stage_22.sv
// Bench for fetch_stage_22: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a rule-level reference model.
module tb_fetch_stage_22;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_valid;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        id_valid;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic [31:0] id_pc_next;
   logic [21:0] id_imm22;
   logic [31:0] fetch_count;

   logic [31:0] mem [0:255];

   int n_cmp  = 0;
   int n_fail = 0;

   fetch_stage_22 dut (
      .clk         (clk),
      .rst         (rst),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .imem_valid  (imem_valid),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .id_valid    (id_valid),
      .id_instr    (id_instr),
      .id_pc       (id_pc),
      .id_pc_next  (id_pc_next),
      .id_imm22    (id_imm22),
      .fetch_count (fetch_count)
   );

   always #5 clk = ~clk;

   // Memory answers combinationally; garbage while in a wait state.
   assign imem_rdata = imem_valid ? mem[imem_addr[7:0]] : 32'hDEAD_BEEF;

   // Reference model: the architectural state after each edge, from the rules.
   logic        model_ok = 1'b0;
   logic [31:0] m_pc = 32'd0, m_instr = 32'd0, m_id_pc = 32'd0, m_id_pc_next = 32'd0, m_count = 32'd0;
   logic        m_valid = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         model_ok <= 1'b1;
         m_pc <= 32'd0; m_valid <= 1'b0; m_instr <= 32'd0;
         m_id_pc <= 32'd0; m_id_pc_next <= 32'd0; m_count <= 32'd0;
      end else if (redirect) begin
         m_pc <= redirect_pc; m_valid <= 1'b0; m_instr <= 32'd0;
      end else if (stall) begin
         m_pc <= m_pc;
      end else if (!imem_valid) begin
         m_valid <= 1'b0; m_instr <= 32'd0;
      end else begin
         m_instr      <= mem[m_pc[7:0]];
         m_id_pc      <= m_pc;
         m_id_pc_next <= m_pc + 32'd1;
         m_valid      <= 1'b1;
         m_pc         <= m_pc + 32'd1;
         m_count      <= m_count + 32'd1;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare every output against the model on the falling edge.
   always @(negedge clk) begin
      if (model_ok) begin
         check("m_imem_addr",   imem_addr,             m_pc);
         check("m_id_valid",    {31'd0, id_valid},     {31'd0, m_valid});
         check("m_id_instr",    id_instr,              m_instr);
         check("m_id_pc",       id_pc,                 m_id_pc);
         check("m_id_pc_next",  id_pc_next,            m_id_pc_next);
         check("m_id_imm22",    {10'd0, id_imm22},     {10'd0, m_instr[21:0]});
         check("m_fetch_count", fetch_count,           m_count);
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
      mem[3] = 32'h003F_FFFF;
      rst = 1'b1; imem_valid = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
      step(2);
      check("rst_id_valid", {31'd0, id_valid}, 32'd0);
      check("rst_id_instr", id_instr, 32'h0000_0000);
      check("rst_id_pc", id_pc, 32'd0);
      check("rst_count", fetch_count, 32'd0);
      check("rst_addr", imem_addr, 32'd0);

      rst = 1'b0;
      step(3);
      check("seq_id_pc", id_pc, 32'd2);
      check("seq_id_instr", id_instr, 32'h1000_0002);
      check("seq_id_pc_next", id_pc_next, 32'd3);
      check("seq_count", fetch_count, 32'd3);

      step(1);
      check("imm_instr", id_instr, 32'h003F_FFFF);
      check("imm22_ones", {10'd0, id_imm22}, 32'h003F_FFFF);

      step(2);
      check("pre_stall_id_pc", id_pc, 32'd5);
      stall = 1'b1;
      step(3);
      check("stall_id_pc", id_pc, 32'd5);
      check("stall_addr", imem_addr, 32'd6);
      check("stall_count", fetch_count, 32'd6);
      check("stall_instr", id_instr, 32'h1000_0005);
      stall = 1'b0;
      step(1);
      check("release_id_pc", id_pc, 32'd6);

      redirect = 1'b1; redirect_pc = 32'h0000_0040;
      step(1);
      check("redir_valid", {31'd0, id_valid}, 32'd0);
      check("redir_instr", id_instr, 32'h0000_0000);
      check("redir_addr", imem_addr, 32'h0000_0040);
      redirect = 1'b0;
      step(1);
      check("target_id_pc", id_pc, 32'h0000_0040);
      check("target_valid", {31'd0, id_valid}, 32'd1);

      redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h0000_0080;
      step(1);
      check("redir_stall_addr", imem_addr, 32'h0000_0080);
      check("redir_stall_valid", {31'd0, id_valid}, 32'd0);
      redirect = 1'b0; stall = 1'b0; imem_valid = 1'b0;
      step(2);
      check("wait_valid", {31'd0, id_valid}, 32'd0);
      check("wait_addr", imem_addr, 32'h0000_0080);
      imem_valid = 1'b1;
      step(1);
      check("resume_id_pc", id_pc, 32'h0000_0080);

      redirect = 1'b1; redirect_pc = 32'h0000_0020;
      step(1);
      redirect = 1'b0; rst = 1'b1; stall = 1'b1;
      step(1);
      check("midrst_addr", imem_addr, 32'd0);
      check("midrst_valid", {31'd0, id_valid}, 32'd0);
      check("midrst_count", fetch_count, 32'd0);
      check("midrst_id_pc_next", id_pc_next, 32'd0);
      rst = 1'b0; stall = 1'b0;

      redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
      step(1);
      redirect = 1'b0;
      step(1);
      check("wrap_id_pc", id_pc, 32'hFFFF_FFFF);
      check("wrap_id_pc_next", id_pc_next, 32'd0);
      check("wrap_addr", imem_addr, 32'd0);
      check("wrap_instr", id_instr, 32'h1000_00FF);

      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      for (int c = 0; c < 3000; c++) begin
         rst         = ($urandom_range(0, 199) == 0);
         stall       = ($urandom_range(0, 99) < 20);
         redirect    = ($urandom_range(0, 99) < 8);
         imem_valid  = ($urandom_range(0, 99) < 80);
         redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF8 + $urandom_range(0, 7)) : $urandom;
         step(1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_stage_22.md
# fetch_stage_22

Instruction-fetch stage plus IF/ID pipeline register for the 32-bit datapath. Holds the PC, drives the instruction-memory address, and captures the returned word into the IF/ID register. Downstream decode and the 22-bit immediate generator consume it: `id_imm22` is the raw immediate field. Handles stall, branch/jump redirect with flush, and instruction-memory wait states.

## Interface
- `ADDR_W`, 32, PC and memory address width.
- `RESET_PC`, 0, PC value loaded by reset.
- `PC_INC`, 1, PC increment per fetched instruction (word-addressed memory).
- `NOP_INSTR`, 32'h0000_0000, word placed in IF/ID on a bubble.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `imem_addr`  out  ADDR_W  fetch address; always equals current PC.
- `imem_rdata`  in  32  instruction word for `imem_addr`, combinational, same cycle.
- `imem_valid`  in  1  `imem_rdata` is valid this cycle; low = memory wait state.
- `stall`  in  1  decode cannot accept; hold PC and IF/ID.
- `redirect`  in  1  taken branch/jump resolved downstream.
- `redirect_pc`  in  ADDR_W  target PC for `redirect`.
- `id_valid`  out  1  IF/ID holds a real instruction.
- `id_instr`  out  32  registered instruction word.
- `id_pc`  out  ADDR_W  PC of `id_instr`.
- `id_pc_next`  out  ADDR_W  `id_pc + PC_INC`, registered.
- `id_imm22`  out  22  `id_instr[21:0]`, combinational slice, fed to the immediate generator.
- `fetch_count`  out  32  number of instructions accepted into IF/ID since reset; wraps modulo 2^32.

## Operation
- Registers: `pc`, IF/ID {`id_valid`, `id_instr`, `id_pc`, `id_pc_next`}, `fetch_count`.
- Reset values:
  - `pc` = RESET_PC.
  - `id_valid` = 0.
  - `id_instr` = NOP_INSTR.
  - `id_pc` = 0.
  - `id_pc_next` = 0.
  - `fetch_count` = 0.
  - Therefore `imem_addr` = RESET_PC and `id_imm22` = NOP_INSTR[21:0].
- Per-edge priority, highest first:
  1. `rst`: load reset values.
  2. `redirect` (regardless of `stall`/`imem_valid`):
     - `pc` ← `redirect_pc`.
     - IF/ID flushed: `id_valid` = 0, `id_instr` = NOP_INSTR.
     - `id_pc` and `id_pc_next` hold.
     - The word fetched this cycle is discarded.
  3. `stall`: `pc` and all IF/ID registers hold; `fetch_count` holds.
  4. `!imem_valid`:
     - `pc` holds.
     - IF/ID takes a bubble: `id_valid` = 0, `id_instr` = NOP_INSTR.
     - `id_pc` and `id_pc_next` hold.
  5. Normal:
     - `id_instr` ← `imem_rdata`, `id_pc` ← `pc`, `id_pc_next` ← `pc + PC_INC`, `id_valid` ← 1.
     - `pc` ← `pc + PC_INC`.
     - `fetch_count` += 1.
- PC arithmetic is unsigned modulo 2^ADDR_W. PC at all-ones + PC_INC wraps to 0 with no error.
- `redirect_pc` is taken as-is; no alignment check.
- Implicit state: FETCH (normal), WAIT (`!imem_valid`), HOLD (`stall`), FLUSH (`redirect`). Each is re-evaluated every cycle; no multi-cycle sequences.

## Timing
- Fetch-to-decode latency: 1 cycle. A word present at edge N with `imem_valid` high and no stall/redirect appears on `id_*` after edge N.
- First instruction after reset: the edge at which `rst` is sampled low captures mem[RESET_PC]. `id_valid` rises after that edge.
- Redirect penalty:
  - Edge of `redirect` loads the target into `pc` and flushes IF/ID.
  - The target instruction reaches IF/ID one edge later.
  - That gives exactly 1 bubble cycle.
- Stall held for k cycles: outputs are unchanged for k cycles, with no lost or duplicated instruction.
- `rst` asserted mid-stream overrides stall/redirect on that edge.
- `id_imm22` has zero added latency relative to `id_instr`.

## Structure
- Shared package:
  - `NOP_INSTR` default.
  - Field constants: `IMM22_MSB`=21, `IMM22_LSB`=0, instruction width 32.
  - Default `RESET_PC`.
- One sub-module: `if_id_reg`. It holds the IF/ID registers with `load`/`flush`/`hold` controls.
- PC update and priority logic stay in the top.

## Test plan
- Reset, then `imem_valid`=1 with mem[i]=0x1000_0000+i: after 3 post-reset edges, `id_pc`=2, `id_instr`=0x1000_0002, `id_pc_next`=3, `fetch_count`=3.
- Fetching 0x003F_FFFF (imm field all ones): `id_imm22`=22'h3F_FFFF in the same cycle `id_instr` updates.
- `stall` high for 3 cycles while `id_pc`=5: `id_*`, `pc`, and `fetch_count` are frozen. On release the next capture is `id_pc`=6.
- `redirect`=1, `redirect_pc`=0x40 while `pc`=7:
  - Next cycle: `id_valid`=0, `id_instr`=NOP_INSTR, `imem_addr`=0x40.
  - Following cycle: `id_pc`=0x40, `id_valid`=1.
- `redirect` and `stall` high together: redirect wins, with `pc`=target and a flush. `imem_valid`=0 for 2 cycles: 2 bubbles, `pc` held, then normal resume.
- `rst` asserted mid-stream with `pc`=0x20: next cycle all outputs at reset values and `imem_addr`=RESET_PC. PC wrap at 0xFFFF_FFFF goes to 0.
